// File: rtl/thermal_controller.sv
// Thermostat with a 4-sample moving-average filter, a deadband fan/heater FSM with
// minimum dwell between actuator changes, and a sensor watchdog that forces a safe idle.
module thermal_controller #(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned MIN_DWELL_S = 5,
  parameter int unsigned TIMEOUT_S   = 3,
  parameter int unsigned HYST        = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sample_done_i,
  input  logic [7:0] temp_i,
  input  logic [7:0] setpoint_i,
  input  logic       enable_i,
  output logic       fan_o,
  output logic       heater_o,
  output logic       sensor_fault_o,
  output logic [7:0] temp_avg_o,
  output logic [1:0] state_o
);

  localparam logic [31:0] DWELL_LOAD = 32'(MIN_DWELL_S * CLK_HZ - 1);
  localparam logic [31:0] WD_LOAD    = 32'(TIMEOUT_S * CLK_HZ - 1);
  localparam logic [8:0]  HYST9      = 9'(HYST);
  localparam logic [7:0]  TEMP_MAX   = 8'd60;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    COOL = 2'b10,
    HEAT = 2'b11
  } state_e;

  logic        done_q;
  logic        accept_q;
  logic [7:0]  temp_q;
  logic [7:0]  buf_q [4];
  logic        primed_q;
  logic        buf_upd_q;
  logic        avg_upd_q;
  logic [7:0]  avg_q;
  logic        fault_q;
  logic [31:0] wd_q;
  logic [31:0] dwell_q;
  state_e      state_q, state_d;
  logic        fan_q, heater_q;

  logic        valid_s;
  logic        wd_expire_s;
  logic        eval_s;
  logic        trans_s;
  logic [9:0]  sum_s;
  logic [8:0]  hi9_s, lo9_s;
  logic [7:0]  hi_s, lo_s;

  // Out-of-range readings are treated as sensor glitches and never reach the filter.
  assign valid_s     = accept_q && (temp_q <= TEMP_MAX);
  // A fresh sample in the expiry cycle wins over the watchdog.
  assign wd_expire_s = (wd_q == 32'd0) && !valid_s;
  assign eval_s      = avg_upd_q && (dwell_q == 32'd0);

  // Rising-edge detect of the sensor done flag and sample capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q   <= 1'b0;
      accept_q <= 1'b0;
      temp_q   <= 8'd0;
    end else begin
      done_q   <= sample_done_i;
      accept_q <= sample_done_i && !done_q;
      if (sample_done_i && !done_q) begin
        temp_q <= temp_i;
      end
    end
  end

  // Sample buffer; an unprimed buffer is flooded so the average starts at the first reading
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= 8'd0;
      end
      primed_q  <= 1'b0;
      buf_upd_q <= 1'b0;
    end else begin
      buf_upd_q <= valid_s;
      if (valid_s) begin
        primed_q <= 1'b1;
        if (!primed_q) begin
          for (int i = 0; i < 4; i++) begin
            buf_q[i] <= temp_q;
          end
        end else begin
          buf_q[0] <= temp_q;
          for (int i = 1; i < 4; i++) begin
            buf_q[i] <= buf_q[i-1];
          end
        end
      end else if (wd_expire_s) begin
        primed_q <= 1'b0;
      end
    end
  end

  // Filter sum and saturating deadband thresholds
  always_comb begin
    sum_s = {2'b00, buf_q[0]} + {2'b00, buf_q[1]} + {2'b00, buf_q[2]} + {2'b00, buf_q[3]};
    hi9_s = {1'b0, setpoint_i} + HYST9;
    lo9_s = {1'b0, setpoint_i} - HYST9;
    if (hi9_s[8]) begin
      hi_s = 8'hFF;
    end else begin
      hi_s = hi9_s[7:0];
    end
    if ({1'b0, setpoint_i} >= HYST9) begin
      lo_s = lo9_s[7:0];
    end else begin
      lo_s = 8'd0;
    end
  end

  // Moving average register; its update pulse opens the FSM evaluation window
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      avg_q     <= 8'd0;
      avg_upd_q <= 1'b0;
    end else begin
      avg_upd_q <= buf_upd_q;
      if (buf_upd_q) begin
        avg_q <= sum_s[9:2];
      end
    end
  end

  // Sensor watchdog and fault flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q    <= WD_LOAD;
      fault_q <= 1'b0;
    end else begin
      if (valid_s) begin
        wd_q    <= WD_LOAD;
        fault_q <= 1'b0;
      end else if (wd_q != 32'd0) begin
        wd_q <= wd_q - 32'd1;
      end else begin
        fault_q <= 1'b1;
      end
    end
  end

  // Next-state logic; fault and disable both override any pending transition
  always_comb begin
    state_d = state_q;
    trans_s = 1'b0;
    if (wd_expire_s || !enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (primed_q && !fault_q) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
        HOLD: begin
          if (eval_s && (avg_q > hi_s)) begin
            state_d = COOL;
          end else if (eval_s && (avg_q < lo_s)) begin
            state_d = HEAT;
          end else begin
            state_d = HOLD;
          end
        end
        COOL: begin
          if (eval_s && (avg_q <= setpoint_i)) begin
            state_d = HOLD;
          end else begin
            state_d = COOL;
          end
        end
        HEAT: begin
          if (eval_s && (avg_q >= setpoint_i)) begin
            state_d = HOLD;
          end else begin
            state_d = HEAT;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      trans_s = (state_q != IDLE) && (state_d != IDLE) && (state_d != state_q);
    end
  end

  // State, actuator and dwell registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      fan_q    <= 1'b0;
      heater_q <= 1'b0;
      dwell_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      fan_q    <= (state_d == COOL);
      heater_q <= (state_d == HEAT);
      if (wd_expire_s) begin
        dwell_q <= 32'd0;
      end else if (trans_s) begin
        dwell_q <= DWELL_LOAD;
      end else if (dwell_q != 32'd0) begin
        dwell_q <= dwell_q - 32'd1;
      end else begin
        dwell_q <= 32'd0;
      end
    end
  end

  assign fan_o          = fan_q;
  assign heater_o       = heater_q;
  assign sensor_fault_o = fault_q;
  assign temp_avg_o     = avg_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_thermal_controller.sv
// Scoreboard bench: stimulus updates a behavioural thermostat model and queues the
// expected outputs with the cycle they are due; a negedge monitor compares them.
module tb_thermal_controller;
  localparam int D = 100;   // dwell cycles
  localparam int W = 300;   // watchdog cycles

  logic       clk = 1'b0, rst_ni = 1'b0, sample_done_i = 1'b0, enable_i = 1'b0;
  logic [7:0] temp_i = 8'd0, setpoint_i = 8'd0;
  logic       fan_o, heater_o, sensor_fault_o;
  logic [7:0] temp_avg_o;
  logic [1:0] state_o;

  int cyc = 0, checks = 0, errors = 0;

  typedef struct {int due; int avg; int st; int fault;} exp_t;
  exp_t q[$];

  // model state: states 0 idle, 1 hold, 2 cool, 3 heat
  int m_buf[4];
  bit m_primed, m_fault, m_en;
  int m_avg, m_state, m_last, m_valid, sp;

  thermal_controller #(.CLK_HZ(100), .MIN_DWELL_S(1), .TIMEOUT_S(3), .HYST(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .sample_done_i(sample_done_i), .temp_i(temp_i),
    .setpoint_i(setpoint_i), .enable_i(enable_i), .fan_o(fan_o), .heater_o(heater_o),
    .sensor_fault_o(sensor_fault_o), .temp_avg_o(temp_avg_o), .state_o(state_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: compare queued expectations when due
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk($sformatf("due@%0d", e.due), e.due, cyc);
      chk($sformatf("avg@%0d", e.due), int'(temp_avg_o), e.avg);
      chk($sformatf("state@%0d", e.due), int'(state_o), e.st);
      chk($sformatf("fault@%0d", e.due), int'(sensor_fault_o), e.fault);
      chk($sformatf("fan@%0d", e.due), int'(fan_o), int'(e.st == 2));
      chk($sformatf("heater@%0d", e.due), int'(heater_o), int'(e.st == 3));
    end
  end

  function automatic void m_reset(int now);
    for (int i = 0; i < 4; i++) m_buf[i] = 0;
    m_primed = 0; m_fault = 0; m_avg = 0; m_state = 0;
    m_last = -100000; m_valid = now;
  endfunction

  // Deadband rules, applied only once the dwell since the last change has elapsed
  function automatic void m_eval(int e);
    int hi, lo, ns;
    hi = (sp + 2 > 255) ? 255 : sp + 2;
    lo = (sp - 2 < 0) ? 0 : sp - 2;
    ns = m_state;
    if (m_state != 0 && (e - m_last) >= D) begin
      if (m_state == 1) ns = (m_avg > hi) ? 2 : ((m_avg < lo) ? 3 : 1);
      else if (m_state == 2) ns = (m_avg <= sp) ? 1 : 2;
      else ns = (m_avg >= sp) ? 1 : 3;
      if (ns != m_state) begin
        m_state = ns;
        m_last = e;
      end
    end
  endfunction

  task automatic send(int t, int gap);
    int k;
    @(posedge clk); #1;
    k = cyc + 1;
    if (k - m_valid >= W) begin
      m_fault = 1; m_state = 0; m_primed = 0; m_last = -100000;
    end
    temp_i = 8'(t);
    sample_done_i = 1'b1;
    if (t <= 60) begin
      if (!m_primed) begin
        for (int i = 0; i < 4; i++) m_buf[i] = t;
      end else begin
        for (int i = 3; i > 0; i--) m_buf[i] = m_buf[i-1];
        m_buf[0] = t;
      end
      m_primed = 1; m_fault = 0; m_valid = k + 1;
      m_avg = (m_buf[0] + m_buf[1] + m_buf[2] + m_buf[3]) / 4;
      if (m_state == 0 && m_en) m_state = 1;
      if (m_en) m_eval(k + 3);
    end
    q.push_back('{k + 3, m_avg, m_state, int'(m_fault)});
    @(posedge clk); #1;
    sample_done_i = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic set_en(bit b);
    @(posedge clk); #1;
    enable_i = b;
    m_en = b;
    if (!b) m_state = 0;
    else if (m_primed && !m_fault && m_state == 0) m_state = 1;
    q.push_back('{cyc + 1, m_avg, m_state, int'(m_fault)});
    repeat (3) @(posedge clk);
  endtask

  task automatic set_sp(int v);
    sp = v;
    setpoint_i = 8'(v);
  endtask

  task automatic wait_timeout();
    int due;
    due = m_valid + W + 2;
    m_fault = 1; m_state = 0; m_primed = 0; m_last = -100000;
    q.push_back('{due, m_avg, 0, 1});
    while (cyc <= due) @(posedge clk);
  endtask

  task automatic reset_check(string tag);
    chk({tag, "_fan"}, int'(fan_o), 0);
    chk({tag, "_heater"}, int'(heater_o), 0);
    chk({tag, "_state"}, int'(state_o), 0);
    chk({tag, "_avg"}, int'(temp_avg_o), 0);
    chk({tag, "_fault"}, int'(sensor_fault_o), 0);
  endtask

  initial begin
    m_en = 0;
    set_sp(0);
    m_reset(0);
    repeat (3) @(posedge clk);
    #1 reset_check("rst");
    rst_ni = 1'b1;
    m_reset(cyc);

    // prime
    enable_i = 1'b1; m_en = 1;
    set_sp(25);
    send(25, 20);
    // cool and back to hold with dwell gating
    for (int i = 0; i < 4; i++) send(30, 20);
    for (int i = 0; i < 4; i++) send(20, 40);
    // low-threshold saturation, then heat
    set_sp(1);
    for (int i = 0; i < 4; i++) send(0, 40);
    set_sp(10);
    send(5, 4);
    // disable during dwell, discarded hot sample
    set_en(0);
    send(70, 20);
    set_en(1);
    // drive into cool, then starve the sensor
    set_sp(3);
    for (int i = 0; i < 4; i++) send(40, 40);
    wait_timeout();
    send(24, 10);

    // asynchronous reset mid-operation
    @(posedge clk); #2;
    rst_ni = 1'b0;
    #1 reset_check("async_rst");
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    m_reset(cyc);
    repeat (10) @(posedge clk);
    #1 chk("post_rst_idle", int'(state_o), 0);
    send(25, 10);

    // randomized phase
    for (int n = 0; n < 60; n++) begin
      if (n % 8 == 0) begin
        case ($urandom_range(4, 0))
          0: set_sp(0);
          1: set_sp(254);
          default: set_sp(int'($urandom_range(45, 10)));
        endcase
      end
      if ($urandom_range(9, 0) == 0) send(int'($urandom_range(90, 61)), int'($urandom_range(40, 4)));
      else send(int'($urandom_range(60, 0)), int'($urandom_range(40, 4)));
    end

    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
